// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the 8088 byte-bus to 16-bit async SRAM bridge.
// Holds the FSM state encoding, the default wait-state count, the request
// record used for latching/tagging core accesses, and a lane-select helper.
package sram_bridge_pkg;

    // Extra cycles the SRAM strobe is held (tAA / tWP); legal range 0..15.
    localparam int unsigned DEF_WAIT_STATES = 2;

    localparam int ADDR_W      = 20;
    localparam int WORD_ADDR_W = 19;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WREC  = 2'd3
    } state_e;

    // One core access as seen on the byte bus. Also used as the tag of the
    // last completed access so identical repeats can be collapsed.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BYTE_W-1:0] wdata;
    } req_t;

    // Byte lane of a 16-bit word: hi=1 selects the upper (odd address) lane.
    function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                    input logic              hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sram_bridge.sv
// Purpose : services the 8088 core's byte bus from a 512Kx16 async SRAM with
//           programmable wait states and a one-word read line buffer.
// Latency : buffer hit stalls 1 cycle; read miss WAIT_STATES+2; write WAIT_STATES+3.
// Backpressure: 'locked' drops combinationally while a new access is pending or
//           in flight; the core is frozen until the access completes.
// Ports   : clock/reset_n (async active-low); pll_locked gates the core enable;
//           address/wdata/we from the core, rdata/locked back to it; sram_* drive
//           the SRAM pads (sram_dq_o/sram_dq_oe feed an external tristate buffer).
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter int unsigned RD_BUFFER   = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic [ADDR_W-1:0]      address,
    input  logic [BYTE_W-1:0]      wdata,
    input  logic                   we,
    output logic [BYTE_W-1:0]      rdata,
    output logic                   locked,
    output logic [WORD_ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0]      sram_dq_o,
    input  logic [WORD_W-1:0]      sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_lb_n,
    output logic                   sram_ub_n
);

    localparam logic [3:0] WS_CNT = WAIT_STATES[3:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [3:0]             cnt_q,       cnt_d;
    req_t                   req_q,       req_d;
    req_t                   tag_q,       tag_d;
    logic                   tag_valid_q, tag_valid_d;
    logic [WORD_W-1:0]      buf_q,       buf_d;
    logic [WORD_ADDR_W-1:0] buf_addr_q,  buf_addr_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [BYTE_W-1:0]      rdata_q,     rdata_d;
    logic [WORD_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [WORD_W-1:0]      dq_o_q,      dq_o_d;
    logic                   dq_oe_q,     dq_oe_d;
    logic                   ce_n_q,      ce_n_d;
    logic                   oe_n_q,      oe_n_d;
    logic                   we_n_q,      we_n_d;
    logic                   lb_n_q,      lb_n_d;
    logic                   ub_n_q,      ub_n_d;

    req_t cur_req;
    logic pending;
    logic buf_hit;

    assign cur_req = {address, we, wdata};

    // A repeat of the last completed access (same address, direction and,
    // for writes, data) is not re-issued: both reads and writes are idempotent,
    // so the core may hold a request across several of its own cycles.
    assign pending = !tag_valid_q
                  || (address != tag_q.addr)
                  || (we != tag_q.we)
                  || (we && (wdata != tag_q.wdata));

    assign buf_hit = (RD_BUFFER != 0) && buf_valid_q
                  && (buf_addr_q == address[ADDR_W-1:1]);

    // Purely combinational from the core's bus; it does not feed back into
    // any core register other than through the core's own enable.
    assign locked = pll_locked && (state_q == ST_IDLE) && !pending;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        buf_d       = buf_q;
        buf_addr_d  = buf_addr_q;
        buf_valid_d = buf_valid_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        lb_n_d      = lb_n_q;
        ub_n_d      = ub_n_q;

        unique case (state_q)
            ST_IDLE: begin
                // Without a stable clock source no new access may start.
                if (pending && pll_locked) begin
                    req_d = cur_req;
                    if (!we && buf_hit) begin
                        rdata_d     = lane_byte(buf_q, address[0]);
                        tag_d       = cur_req;
                        tag_valid_d = 1'b1;
                    end else if (!we) begin
                        state_d     = ST_READ;
                        cnt_d       = WS_CNT;
                        sram_addr_d = address[ADDR_W-1:1];
                        ce_n_d      = 1'b0;
                        oe_n_d      = 1'b0;
                        lb_n_d      = 1'b0;
                        ub_n_d      = 1'b0;
                    end else begin
                        state_d     = ST_WRITE;
                        cnt_d       = WS_CNT;
                        sram_addr_d = address[ADDR_W-1:1];
                        dq_o_d      = {wdata, wdata};
                        dq_oe_d     = 1'b1;
                        ce_n_d      = 1'b0;
                        we_n_d      = 1'b0;
                        lb_n_d      = address[0];
                        ub_n_d      = !address[0];
                    end
                end
            end

            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    buf_d       = sram_dq_i;
                    buf_addr_d  = req_q.addr[ADDR_W-1:1];
                    buf_valid_d = 1'b1;
                    rdata_d     = lane_byte(sram_dq_i, req_q.addr[0]);
                    tag_d       = req_q;
                    tag_valid_d = 1'b1;
                    ce_n_d      = 1'b1;
                    oe_n_d      = 1'b1;
                    lb_n_d      = 1'b1;
                    ub_n_d      = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WRITE: begin
                if (cnt_q == 4'd0) begin
                    // we_n rises first while data and chip enable stay put,
                    // giving the SRAM a data-hold cycle.
                    we_n_d  = 1'b1;
                    state_d = ST_WREC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WREC: begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                // Keep the line buffer coherent with the SRAM contents.
                if (buf_valid_q && (buf_addr_q == req_q.addr[ADDR_W-1:1])) begin
                    if (req_q.addr[0]) begin
                        buf_d[15:8] = req_q.wdata;
                    end else begin
                        buf_d[7:0]  = req_q.wdata;
                    end
                end
                tag_d       = req_q;
                tag_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            buf_q       <= '0;
            buf_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            buf_q       <= buf_d;
            buf_addr_q  <= buf_addr_d;
            buf_valid_q <= buf_valid_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
        end
    end

    assign rdata      = rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;

endmodule
